gpio_debounce_bank: RTL and testbench

GPIO_DEBOUNCE_BANK -- requirements
Module: gpio_debounce_bank

---
 rtl/gpio_debounce_bank.sv | 87 ++++++++
 tb/tb_gpio_debounce_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce_bank.sv
// GPIO input bank: per-bit synchronizer, debounce counter, edge pulses, sticky pending flags
// with a maskable level interrupt, plus a registered LED output word.
module gpio_debounce_bank #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_sw,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_pending,
    input  logic [WIDTH-1:0] i_clr,
    input  logic [WIDTH-1:0] i_irq_en,
    output logic             o_irq,
    input  logic [WIDTH-1:0] i_gpio_out,
    output logic [WIDTH-1:0] o_led
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]                  sw_q, sw_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic [WIDTH-1:0]                  pend_q, pend_d;
    logic [WIDTH-1:0]                  led_q, led_d;
    logic [WIDTH-1:0]                  sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_sw};
        cnt_d  = cnt_q;
        sw_d   = sw_q;
        rise_d = '0;
        fall_d = '0;
        // Any sample agreeing with the debounced level restarts the count from zero.
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_last[i] == sw_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]  = '0;
                sw_d[i]   = sync_last[i];
                rise_d[i] = sync_last[i];
                fall_d[i] = ~sync_last[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        // A new event wins over a clear arriving on the same edge.
        pend_d = (pend_q & ~i_clr) | rise_d | fall_d;
        led_d  = i_gpio_out;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            cnt_q  <= '0;
            sw_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            pend_q <= '0;
            led_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            sw_q   <= sw_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
            led_q  <= led_d;
        end
    end

    assign o_sw      = sw_q;
    assign o_rise    = rise_q;
    assign o_fall    = fall_q;
    assign o_pending = pend_q;
    assign o_led     = led_q;
    assign o_irq     = |(pend_q & i_irq_en);

endmodule

// File: tb/tb_gpio_debounce_bank.sv
// Randomized and directed bench for gpio_debounce_bank against a run-length reference model.
module tb_gpio_debounce_bank;

    localparam int W = 4;
    localparam int D = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] i_sw, o_sw, o_rise, o_fall, o_pending, i_clr, i_irq_en, i_gpio_out, o_led;
    logic         o_irq;

    gpio_debounce_bank #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
        .clk(clk), .rstn(rstn), .i_sw(i_sw), .o_sw(o_sw), .o_rise(o_rise), .o_fall(o_fall),
        .o_pending(o_pending), .i_clr(i_clr), .i_irq_en(i_irq_en), .o_irq(o_irq),
        .i_gpio_out(i_gpio_out), .o_led(o_led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rise1_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw input delayed S samples, and a count of consecutive
    // disagreeing samples; D in a row flips the debounced level.
    logic [W-1:0] m_dl [S];
    logic [W-1:0] m_sw, m_rise, m_fall, m_pend, m_led;
    int           m_run [W];

    task automatic model_reset();
        for (int k = 0; k < S; k++) m_dl[k] = '0;
        m_sw = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_led = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] seen;
        seen = m_dl[S-1];
        for (int k = S - 1; k > 0; k--) m_dl[k] = m_dl[k-1];
        m_dl[0] = i_sw;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (seen[i] != m_sw[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == D) begin
                    m_sw[i] = seen[i];
                    m_run[i] = 0;
                    if (seen[i]) m_rise[i] = 1'b1;
                    else         m_fall[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_pend = (m_pend & ~i_clr) | m_rise | m_fall;
        m_led  = i_gpio_out;
    endtask

    // Called at a negedge with inputs already set; leaves i_clr deasserted.
    task automatic step();
        #1 check("irq_pre", 32'(o_irq), 32'(|(m_pend & i_irq_en)));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("o_sw", 32'(o_sw), 32'(m_sw));
        check("o_rise", 32'(o_rise), 32'(m_rise));
        check("o_fall", 32'(o_fall), 32'(m_fall));
        check("o_pending", 32'(o_pending), 32'(m_pend));
        check("o_led", 32'(o_led), 32'(m_led));
        if (o_rise[1]) rise1_cnt++;
        i_clr = '0;
    endtask

    task automatic wait_level(input int b, input logic lvl, output int lat);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            step();
            if (o_sw[b] == lvl) lat = k;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sw"}, 32'(o_sw), 32'h0);
        check({tag, "_rise"}, 32'(o_rise), 32'h0);
        check({tag, "_fall"}, 32'(o_fall), 32'h0);
        check({tag, "_pend"}, 32'(o_pending), 32'h0);
        check({tag, "_led"}, 32'(o_led), 32'h0);
        check({tag, "_irq"}, 32'(o_irq), 32'h0);
    endtask

    int lat;

    initial begin
        rstn = 1'b1; i_sw = '0; i_clr = '0; i_irq_en = '1; i_gpio_out = '0;
        model_reset();
        #2 rstn = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Clean step on bit 0
        i_sw = 4'b0001;
        wait_level(0, 1'b1, lat);
        check("lat_step0", 32'(lat), 32'd6);
        check("pend_step0", 32'(o_pending), 32'h1);

        // Bounce on bit 1, then hold high
        rise1_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) i_sw[1] = ~i_sw[1];
            step();
            check("bounce_hold", 32'(o_sw[1]), 32'h0);
        end
        i_sw[1] = 1'b1;
        wait_level(1, 1'b1, lat);
        check("lat_bounce1", 32'(lat), 32'd6);
        step();
        check("rise1_count", 32'(rise1_cnt), 32'd1);

        // Interrupt masking and clear on bit 2
        i_sw[2] = 1'b1;
        wait_level(2, 1'b1, lat);
        check("lat_bit2", 32'(lat), 32'd6);
        i_irq_en = 4'h0;
        #1 check("irq_masked", 32'(o_irq), 32'h0);
        i_irq_en = 4'h4;
        #1 check("irq_enabled", 32'(o_irq), 32'h1);
        i_clr = 4'h4;
        step();
        check("pend2_cleared", 32'(o_pending[2]), 32'h0);
        #1 check("irq_after_clr", 32'(o_irq), 32'h0);

        // Clear colliding with a fall event on bit 3
        i_sw[3] = 1'b1;
        wait_level(3, 1'b1, lat);
        i_clr = 4'h8;
        step();
        i_sw[3] = 1'b0;
        repeat (5) step();
        i_clr = 4'h8;
        step();
        check("fall3_fired", 32'(o_fall[3]), 32'h1);
        check("pend3_kept", 32'(o_pending[3]), 32'h1);
        i_clr = 4'h8;
        step();
        check("pend3_cleared", 32'(o_pending[3]), 32'h0);

        // LED register
        i_gpio_out = 4'hA;
        step();
        check("led_A", 32'(o_led), 32'hA);
        i_gpio_out = 4'h5;
        step();
        check("led_5", 32'(o_led), 32'h5);

        // Reset mid-count, switch held through release
        i_sw = '0;
        repeat (8) step();
        i_sw[0] = 1'b1;
        repeat (4) step();
        rstn = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        wait_level(0, 1'b1, lat);
        check("lat_after_reset", 32'(lat), 32'd6);
        check("rise_after_reset", 32'(o_rise[0]), 32'h1);

        // Randomized traffic with one asynchronous reset in the middle
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 9) == 0) i_sw[b] = ~i_sw[b];
            i_clr      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            i_irq_en   = 4'($urandom);
            i_gpio_out = 4'($urandom);
            if (c == 200) begin
                rstn = 1'b0;
                #1 check_all_zero("rndreset");
                model_reset();
                @(negedge clk);
                rstn = 1'b1;
                i_clr = '0;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
